// File: rtl/uart_pkg.sv
// Shared constants and drain-FSM state encoding for the UART transmit buffer.
package uart_pkg;
    localparam int BYTE_W      = 8;
    localparam int ACK_TIMEOUT = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_ACK  = 2'd2,
        S_WAIT = 2'd3
    } tx_state_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 register array: synchronous write, combinational read, no reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [BYTE_W-1:0]     wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [BYTE_W-1:0]     rd_data
);
    logic [BYTE_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that drains into the serial transmitter via a data/strobe/ready handshake.
// Define UART_TX_FIFO_STRIP8_EN to clear bit 7 of every byte before it is stored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     wr_data,
    input  logic                  wr_strobe,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_strobe,
    input  logic                  tx_ready,
    output tx_state_t             dbg_state
);
    localparam int                ACK_W     = $clog2(ACK_TIMEOUT);
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(2**DEPTH_LOG2);

    tx_state_t             state, state_nxt;
    logic [ACK_W-1:0]      ack_cnt;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic [BYTE_W-1:0]     wr_byte, rd_byte;
    logic                  pop, wr_acc;

`ifdef UART_TX_FIFO_STRIP8_EN
    assign wr_byte = {1'b0, wr_data[BYTE_W-2:0]};
`else
    assign wr_byte = wr_data;
`endif

    uart_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_byte),
        .rd_addr (rd_ptr),
        .rd_data (rd_byte)
    );

    // A flush edge never pops, so the cleared FIFO cannot hand out a stale byte.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: if (!empty && tx_ready && !flush) begin
                pop       = 1'b1;
                state_nxt = S_SEND;
            end
            S_SEND: state_nxt = S_ACK;
            S_ACK: begin
                if (!tx_ready)                state_nxt = S_WAIT;
                else if (ack_cnt == ACK_LAST) state_nxt = S_IDLE;
            end
            S_WAIT: if (tx_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign wr_acc = wr_strobe && !flush && (!full || pop);

    always_comb begin
        count_nxt = count;
        if (flush)              count_nxt = '0;
        else if (wr_acc && !pop) count_nxt = count + 1'b1;
        else if (pop && !wr_acc) count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ack_cnt   <= '0;
            tx_strobe <= 1'b0;
            tx_data   <= '0;
        end else begin
            state     <= state_nxt;
            tx_strobe <= (state == S_SEND);
            ack_cnt   <= (state == S_ACK) ? ack_cnt + ACK_W'(1) : '0;
            if (pop) tx_data <= rd_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_acc)               wr_ptr   <= wr_ptr + 1'b1;
                if (pop)                  rd_ptr   <= rd_ptr + 1'b1;
                if (wr_strobe && !wr_acc) overflow <= 1'b1;
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == DEPTH_CNT);
        end
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized checks of uart_tx_fifo against a queue-based transmitter model.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_strobe = 1'b0;
    logic        flush = 1'b0;
    logic        full, empty, overflow, tx_strobe;
    logic [4:0]  count;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    tx_state_t   dbg_state;

    int vectors = 0;
    int miscompares = 0;

    // Transmitter model controls.
    logic        hold = 1'b0;
    logic        rand_busy = 1'b0;
    int          busy_len = 3;
    int          busy = 0;
    int          strobe_cnt = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_strobe (wr_strobe),
        .flush     (flush),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .tx_data   (tx_data),
        .tx_strobe (tx_strobe),
        .tx_ready  (tx_ready),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] b);
`ifdef UART_TX_FIFO_STRIP8_EN
        return b & 8'h7F;
`else
        return b;
`endif
    endfunction

    // Transmitter: latches a byte on each strobe, then stays busy (ready low) for a while.
    always @(negedge clk) begin
        if (!rst && tx_strobe === 1'b1) begin
            strobe_cnt++;
            rx_q.push_back(tx_data);
            check("strobe_while_ready", tx_ready, 1'b1);
            busy = rand_busy ? int'($urandom_range(1, 5)) : busy_len;
        end
        tx_ready = (hold || busy > 0) ? 1'b0 : 1'b1;
        if (busy > 0) busy--;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_data   = b;
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) tick();
        check(tag, rx_q.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && !(dbg_state == S_IDLE && tx_ready); i++) tick();
        check(tag, {tx_ready, dbg_state == S_IDLE}, 2'b11);
    endtask

    task automatic compare_rx(input string tag);
        int n;
        n = exp_q.size();
        check({tag, "_len"}, rx_q.size(), n);
        for (int i = 0; i < n; i++)
            check(tag, (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD, exp_q[i]);
        exp_q.delete();
        rx_q.delete();
    endtask

    initial begin
        int s0, k, gap;
        logic [7:0] b;

        // Reset state
        repeat (3) tick();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tx_strobe", tx_strobe, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_state", dbg_state, S_IDLE);
        rst = 1'b0;
        tick();

        // Single byte latency
        write_byte(8'h41);
        check("t1_count_e0", count, 1);
        check("t1_empty_e0", empty, 0);
        check("t1_strobe_e0", tx_strobe, 0);
        tick();
        check("t1_tx_data_e1", tx_data, exp_byte(8'h41));
        check("t1_count_e1", count, 0);
        check("t1_empty_e1", empty, 1);
        check("t1_strobe_e1", tx_strobe, 0);
        check("t1_state_e1", dbg_state, S_SEND);
        tick();
        check("t1_strobe_e2", tx_strobe, 1);
        tick();
        check("t1_strobe_e3", tx_strobe, 0);
        wait_idle("t1_idle");
        exp_q.push_back(exp_byte(8'h41));
        compare_rx("t1_rx");

        // Fill to full, then overflow
        hold = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) write_byte(8'(i));
        write_byte(8'hFF);
        tick();
        check("t2_full", full, 1);
        check("t2_count", count, 16);
        check("t2_overflow", overflow, 1);
        check("t2_empty", empty, 0);
        hold = 1'b0;
        wait_rx("t2_drain", 16, 600);
        repeat (20) tick();
        for (int i = 0; i < 16; i++) exp_q.push_back(exp_byte(8'(i)));
        compare_rx("t2_rx");
        check("t2_overflow_sticky", overflow, 1);
        check("t2_empty_after", empty, 1);
        wait_idle("t2_idle");

        // Flush beats a same-edge write; then write+pop while full
        flush = 1'b1;
        wr_data = 8'hEE;
        wr_strobe = 1'b1;
        tick();
        flush = 1'b0;
        wr_strobe = 1'b0;
        check("t3_flush_count", count, 0);
        check("t3_flush_overflow", overflow, 0);
        check("t3_flush_empty", empty, 1);
        hold = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
        check("t3_full", full, 1);
        check("t3_overflow_pre", overflow, 0);
        hold = 1'b0;
        tick();
        write_byte(8'h30);
        check("t3_count_wrpop", count, 16);
        check("t3_full_wrpop", full, 1);
        check("t3_overflow_wrpop", overflow, 0);
        check("t3_state_wrpop", dbg_state, S_SEND);
        wait_rx("t3_drain", 17, 600);
        repeat (10) tick();
        for (int i = 0; i < 16; i++) exp_q.push_back(exp_byte(8'h20 + 8'(i)));
        exp_q.push_back(exp_byte(8'h30));
        compare_rx("t3_rx");
        wait_idle("t3_idle");

        // Slow transmitter: ready low 10 cycles per byte
        busy_len = 10;
        s0 = strobe_cnt;
        write_byte(8'h50);
        write_byte(8'h51);
        write_byte(8'h52);
        wait_rx("t4_drain", 3, 300);
        repeat (30) tick();
        check("t4_strobes", strobe_cnt - s0, 3);
        exp_q.push_back(exp_byte(8'h50));
        exp_q.push_back(exp_byte(8'h51));
        exp_q.push_back(exp_byte(8'h52));
        compare_rx("t4_rx");
        wait_idle("t4_idle");

        // Flush during S_WAIT with 5 queued
        s0 = strobe_cnt;
        for (int i = 0; i < 6; i++) write_byte(8'h60 + 8'(i));
        check("t5_state_pre", dbg_state, S_WAIT);
        check("t5_count_pre", count, 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_count", count, 0);
        check("t5_empty", empty, 1);
        check("t5_overflow", overflow, 0);
        check("t5_state_inflight", dbg_state, S_WAIT);
        repeat (40) tick();
        check("t5_strobes", strobe_cnt - s0, 1);
        check("t5_state_end", dbg_state, S_IDLE);
        exp_q.push_back(exp_byte(8'h60));
        compare_rx("t5_rx");

        // Bit 7 handling
        busy_len = 3;
        write_byte(8'hC1);
        wait_rx("t6_drain", 1, 100);
        exp_q.push_back(exp_byte(8'hC1));
        compare_rx("t6_rx");
        wait_idle("t6_idle");

        // Randomized bursts with random transmitter busy time
        rand_busy = 1'b1;
        for (int r = 0; r < 8; r++) begin
            k = $urandom_range(1, 16);
            for (int i = 0; i < k; i++) begin
                b = 8'($urandom);
                exp_q.push_back(exp_byte(b));
                write_byte(b);
                gap = $urandom_range(0, 3);
                repeat (gap) tick();
            end
            wait_rx("rnd_drain", k, 1000);
            repeat (10) tick();
            compare_rx("rnd_rx");
            check("rnd_overflow", overflow, 0);
            check("rnd_empty", empty, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-wide transmit buffer that sits directly upstream of the serial transmitter.
- Absorbs bursts of console output bytes from the CPU-side I/O logic and drains them one at a time into the transmitter.
- Uses the transmitter's data/strobe/ready handshake: one-cycle strobe, ready high only while the transmitter is idle.
- Gives the PDP-8 teleprinter path back-to-back throughput without the CPU waiting a full character time per byte.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in bytes (DEPTH = 2**DEPTH_LOG2; default 16 entries).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_data  in  8  byte to enqueue.
- wr_strobe  in  1  one-cycle enqueue request.
- flush  in  1  synchronous clear of FIFO contents and overflow flag.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  DEPTH_LOG2+1  bytes currently held (0..DEPTH).
- overflow  out  1  sticky: a write was dropped.
- tx_data  out  8  byte presented to the transmitter.
- tx_strobe  out  1  one-cycle load pulse to the transmitter.
- tx_ready  in  1  transmitter idle / ready for a byte.

Behaviour:
- Reset (async, rst=1): rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, overflow=0, tx_strobe=0, tx_data=8'h00, FSM=S_IDLE. Storage contents are not reset.
- Pointers: DEPTH_LOG2 bits, wrap modulo DEPTH. Count is separate, DEPTH_LOG2+1 bits; full/empty decode from count, registered.
- Write acceptance: on a clk edge with wr_strobe=1, the write is accepted if full=0 OR a pop occurs on the same edge. Accepted: mem[wr_ptr]<=wr_data, wr_ptr++.
- Dropped write (full=1 and no pop): FIFO unchanged, overflow<=1. Overflow stays set until flush or rst.
- Pop: occurs on the edge where the FSM leaves S_IDLE for S_SEND. It captures tx_data<=mem[rd_ptr] and then rd_ptr++.
- Count update: +1 on accepted write only, -1 on pop only, unchanged on both or neither.
- Drain FSM states:
  - S_IDLE: if empty=0 && tx_ready=1, pop and go to S_SEND.
  - S_SEND: tx_strobe=1 (registered, exactly one cycle); go to S_ACK.
  - S_ACK: wait for tx_ready=0 (transmitter left idle), then go to S_WAIT. Timeout: if tx_ready stays high for 4 cycles, go to S_IDLE.
  - S_WAIT: wait for tx_ready=1, then go to S_IDLE.
- Latency: write sampled on edge E0 into an empty FIFO with tx_ready=1 → pop on E1 → tx_strobe high in the cycle after E2, with tx_data already valid in the cycle after E1.
- Back-to-back: tx_data is held stable from the pop until the next pop.
- flush (synchronous): pointers, count and overflow are cleared. If the FSM is in S_SEND/S_ACK/S_WAIT, the in-flight byte still completes its handshake. flush has priority over a same-edge write, which is dropped without setting overflow.
- Reset mid-operation: immediate return to the reset state. A byte already handed to the transmitter is not recalled.

Optional Feature:
- Macro: UART_TX_FIFO_STRIP8_EN.
- Defined: bit 7 of every byte is forced to 0 at the write port, before storage. This strips the PDP-8 mark-parity bit for 7-bit terminals.
- Undefined: bytes pass through unmodified.
- No other behaviour differs.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encodings S_IDLE/S_SEND/S_ACK/S_WAIT (2-bit).
  - The S_ACK timeout constant (4).
  - UART byte width constant (8).
- One natural sub-module: uart_fifo_mem, a simple dual-port DEPTH×8 register array with synchronous write and combinational read, no reset.

Test Plan:
- Reset then single write 8'h41 with tx_ready=1 → tx_data=8'h41, one-cycle tx_strobe in the cycle after E2; count 0→1→0; empty returns to 1.
- Write 16 bytes 8'h00..8'h0F with tx_ready=0, then a 17th byte 8'hFF → full=1, count=16, overflow=1; release tx_ready (transmitter model) → bytes emerge in order 00..0F; 8'hFF never appears.
- With full=1, write and pop on the same edge → write accepted, count stays 16, overflow stays 0.
- Transmitter model drops ready for 10 cycles per byte; write 3 bytes → exactly 3 tx_strobe pulses, each only after ready returns high; no pulse while ready=0.
- flush during S_WAIT holding 5 queued bytes → count=0, overflow=0, the in-flight byte still completes, no further strobes.
- Compiled with UART_TX_FIFO_STRIP8_EN, write 8'hC1 → tx_data=8'h41. Without the macro → tx_data=8'hC1.
